// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: iterative AES-128 inverse key scheduler.
// Expands the cipher key forward to round key 10. It then walks the schedule
// backwards one round per accepted key, so only one round key is ever stored.
module aes_inv_key_sched #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key,
  input  logic         rk_ready,
  output logic         busy,
  output logic         rk_valid,
  output logic [0:127] rk,
  output logic [3:0]   rk_round,
  output logic         done
);

  // Only the AES-128 geometry is implemented; anything else is rejected at elaboration.
  if (NR != 10 || NK != 4) begin : gen_cfg_error
    $error("aes_inv_key_sched supports only NR=10 and NK=4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_e;

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte x lives at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [0:127] w_q, w_d;
  logic [3:0]   r_q, r_d;
  logic         busy_q, busy_d;
  logic         rk_valid_q, rk_valid_d;
  logic         done_q, done_d;

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  b0, b1, b2, b3;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  sbox_in;
  logic [31:0]  t_word;
  logic [3:0]   rcon_idx;
  logic [0:127] fwd_key;
  logic [0:127] inv_key;

  assign a0 = w_q[0:31];
  assign a1 = w_q[32:63];
  assign a2 = w_q[64:95];
  assign a3 = w_q[96:127];

  // Round datapath: one shared SubWord/Rcon term t serves both the forward
  // step (fed by a3) and the inverse step (fed by the recovered old a3 = b3).
  always_comb begin
    b1       = a1 ^ a0;
    b2       = a2 ^ a1;
    b3       = a3 ^ a2;
    sbox_in  = (state_q == EMIT) ? b3 : a3;
    rcon_idx = (state_q == EMIT) ? r_q : r_q + 4'd1;
    t_word   = sub_word(rot_word(sbox_in)) ^ {rcon(rcon_idx), 24'h000000};
    f0       = a0 ^ t_word;
    f1       = a1 ^ f0;
    f2       = a2 ^ f1;
    f3       = a3 ^ f2;
    b0       = a0 ^ t_word;
    fwd_key  = {f0, f1, f2, f3};
    inv_key  = {b0, b1, b2, b3};
  end

  // Next-state logic; the registered flags are derived from the next state
  // so every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    r_d        = r_q;
    busy_d     = 1'b0;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          w_d     = key;
          r_d     = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        w_d = fwd_key;
        r_d = r_q + 4'd1;
        if (r_q == 4'd9) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_valid_q && rk_ready) begin
          if (r_q == 4'd0) begin
            state_d = FIN;
          end else begin
            w_d = inv_key;
            r_d = r_q - 4'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d == FWD) || (state_d == EMIT);
    rk_valid_d = (state_d == EMIT);
    done_d     = (state_d == FIN);
  end

  // State, key and flag registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      w_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign done     = done_q;
  assign rk       = w_q;
  assign rk_round = r_q;

endmodule
